// File: rtl/imm_extend_stage_if.sv
// Valid/ready bus of the immediate-extension stage: raw immediate in, extended immediate out.
// The stage uses the slave modport; the decode/execute side uses the master modport.
interface imm_extend_stage_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int OPC_W = 6
) ();
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [OPC_W-1:0] in_opcode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [1:0]       out_mode;

   modport master (
      output in_valid, in_imm, in_opcode, out_ready,
      input  in_ready, out_valid, out_data, out_mode
   );

   modport slave (
      input  in_valid, in_imm, in_opcode, out_ready,
      output in_ready, out_valid, out_data, out_mode
   );
endinterface

// File: rtl/imm_extend_stage.sv
// Registered MIPS immediate extension (sign, zero, upper-load) behind a valid/ready
// handshake with a two-entry skid buffer so backpressure never loses or repeats an entry.
module imm_extend_stage #(
   parameter int               IN_W     = 16,
   parameter int               OUT_W    = 32,
   parameter int               OPC_W    = 6,
   parameter logic [OPC_W-1:0] OPC_ANDI = 6'h0C,
   parameter logic [OPC_W-1:0] OPC_ORI  = 6'h0D,
   parameter logic [OPC_W-1:0] OPC_XORI = 6'h0E,
   parameter logic [OPC_W-1:0] OPC_LUI  = 6'h0F
) (
   input logic              clk,
   input logic              rst,
   input logic              flush,
   imm_extend_stage_if.slave bus
);

   if (IN_W < 1) begin : g_in_w_check
      $error("imm_extend_stage: IN_W must be at least 1");
   end
   if (OUT_W <= IN_W) begin : g_out_w_check
      $error("imm_extend_stage: OUT_W must be greater than IN_W");
   end

   typedef enum logic [1:0] {
      MODE_SEXT = 2'd0,
      MODE_ZEXT = 2'd1,
      MODE_LUI  = 2'd2
   } mode_e;

   logic [OUT_W-1:0] new_data;
   mode_e            new_mode;

   logic             m_valid;
   logic [OUT_W-1:0] m_data;
   mode_e            m_mode;
   logic             s_valid;
   logic [OUT_W-1:0] s_data;
   mode_e            s_mode;

   logic accept;
   logic drain;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      new_mode = MODE_SEXT;
      new_data = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
      if (bus.in_opcode == OPC_ANDI || bus.in_opcode == OPC_ORI || bus.in_opcode == OPC_XORI) begin
         new_mode = MODE_ZEXT;
         new_data = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
      end else if (bus.in_opcode == OPC_LUI) begin
         new_mode = MODE_LUI;
         new_data = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};
      end
   end

   // in_ready depends only on registered state, keeping out_ready off the upstream timing path.
   assign accept = bus.in_valid & ~s_valid;
   assign drain  = m_valid & bus.out_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the skid data is never reset; only valid bits and the visible output data need a defined value.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_data  <= '0;
         m_mode  <= MODE_SEXT;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (!m_valid) begin
         // S is always empty while M is empty, so an accept lands directly in M.
         if (accept) begin
            m_valid <= 1'b1;
            m_data  <= new_data;
            m_mode  <= new_mode;
         end
      end else if (drain) begin
         if (s_valid) begin
            m_data  <= s_data;
            m_mode  <= s_mode;
            s_valid <= 1'b0;
         end else if (accept) begin
            m_data <= new_data;
            m_mode <= new_mode;
         end else begin
            m_valid <= 1'b0;
         end
      end else if (accept) begin
         s_valid <= 1'b1;
         s_data  <= new_data;
         s_mode  <= new_mode;
      end
   end

   assign bus.in_ready  = ~s_valid;
   assign bus.out_valid = m_valid;
   assign bus.out_data  = m_data;
   assign bus.out_mode  = m_mode;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed steps plus a randomized run against a
// queue model whose expected values come from the extension rules in plain arithmetic.
module tb_imm_extend_stage;

   typedef struct packed {
      logic [1:0]  mode;
      logic [63:0] data;
   } exp_t;

   logic clk;
   logic rst;
   logic flush32;
   logic flush64;
   int   checks;
   int   failures;
   exp_t q[$];

   imm_extend_stage_if #(.IN_W(16), .OUT_W(32), .OPC_W(6)) b32 ();
   imm_extend_stage_if #(.IN_W(16), .OUT_W(64), .OPC_W(6)) b64 ();

   imm_extend_stage #(.IN_W(16), .OUT_W(32), .OPC_W(6)) u_dut32 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush32),
      .bus   (b32.slave)
   );

   imm_extend_stage #(.IN_W(16), .OUT_W(64), .OPC_W(6)) u_dut64 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush64),
      .bus   (b64.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected extension computed numerically: sign-extension as a negative value wrapped to
   // out_w bits, upper-load as multiplication by 2**(out_w-16).
   function automatic exp_t ref_ext(input int out_w, input logic [15:0] imm, input logic [5:0] opc);
      exp_t   r;
      longint v;
      if (opc inside {6'h0C, 6'h0D, 6'h0E}) begin
         r.mode = 2'd1;
         v      = longint'(imm);
      end else if (opc == 6'h0F) begin
         r.mode = 2'd2;
         v      = longint'(imm) * (longint'(1) << (out_w - 16));
      end else begin
         r.mode = 2'd0;
         v      = imm[15] ? longint'(imm) - 65536 : longint'(imm);
      end
      if (out_w < 64) v = v & ((longint'(1) << out_w) - 1);
      r.data = v;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clock of the 32-bit stage: drive, advance the model, then compare every output.
   task automatic cycle(input bit v, input logic [15:0] imm, input logic [5:0] opc,
                        input bit rdy, input bit fl, output bit acc, output bit drn);
      b32.in_valid  = v;
      b32.in_imm    = imm;
      b32.in_opcode = opc;
      b32.out_ready = rdy;
      flush32       = fl;
      acc = !fl && v && (q.size() < 2);
      drn = !fl && rdy && (q.size() > 0);
      step();
      if (fl) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(ref_ext(32, imm, opc));
      end
      check("in_ready", 64'(b32.in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(b32.out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check("out_data", 64'(b32.out_data), q[0].data);
         check("out_mode", 64'(b32.out_mode), 64'(q[0].mode));
      end
   endtask

   initial begin
      logic [15:0] list[8];
      logic [15:0] imm;
      logic [5:0]  opc;
      bit          acc;
      bit          drn;
      int          idx;
      int          accepted;
      int          drained;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      flush32  = 1'b0;
      flush64  = 1'b0;
      b32.in_valid  = 1'b0;
      b32.in_imm    = '0;
      b32.in_opcode = '0;
      b32.out_ready = 1'b0;
      b64.in_valid  = 1'b0;
      b64.in_imm    = '0;
      b64.in_opcode = '0;
      b64.out_ready = 1'b1;

      // Reset held for two cycles.
      step();
      step();
      check("rst_out_valid", 64'(b32.out_valid), 64'd0);
      check("rst_in_ready", 64'(b32.in_ready), 64'd1);
      check("rst_out_data", 64'(b32.out_data), 64'd0);
      check("rst_out_mode", 64'(b32.out_mode), 64'd0);
      rst = 1'b0;

      // One immediate through each mode, back to back.
      cycle(1'b1, 16'h8001, 6'h08, 1'b1, 1'b0, acc, drn);
      check("sext_data", 64'(b32.out_data), 64'h0000_0000_FFFF_8001);
      check("sext_mode", 64'(b32.out_mode), 64'd0);
      cycle(1'b1, 16'h8001, 6'h0D, 1'b1, 1'b0, acc, drn);
      check("zext_data", 64'(b32.out_data), 64'h0000_0000_0000_8001);
      check("zext_mode", 64'(b32.out_mode), 64'd1);
      cycle(1'b1, 16'h8001, 6'h0F, 1'b1, 1'b0, acc, drn);
      check("lui_data", 64'(b32.out_data), 64'h0000_0000_8001_0000);
      check("lui_mode", 64'(b32.out_mode), 64'd2);
      cycle(1'b0, 16'h0000, 6'h00, 1'b1, 1'b0, acc, drn);
      check("idle_out_valid", 64'(b32.out_valid), 64'd0);

      // Eight immediates with backpressure from the second cycle on.
      for (int i = 0; i < 8; i++) list[i] = 16'h1000 * 16'(i) + 16'h00A5 + 16'(i);
      idx      = 0;
      accepted = 0;
      for (int c = 0; c < 6; c++) begin
         cycle(idx < 8, list[idx % 8], 6'(c % 16), c == 0, 1'b0, acc, drn);
         if (acc) begin
            idx++;
            accepted++;
         end
      end
      check("stall_accepts", 64'(accepted), 64'd2);
      check("stall_in_ready", 64'(b32.in_ready), 64'd0);
      drained = 0;
      for (int c = 0; c < 40 && drained < 8; c++) begin
         cycle(idx < 8, list[idx % 8], 6'((idx + 2) % 16), 1'b1, 1'b0, acc, drn);
         if (acc) idx++;
         if (drn) drained++;
      end
      check("stream_drained", 64'(drained), 64'd8);
      check("stream_empty", 64'(b32.out_valid), 64'd0);

      // Flush with both registers full and a new immediate offered in the same cycle.
      cycle(1'b1, 16'h1111, 6'h0C, 1'b0, 1'b0, acc, drn);
      cycle(1'b1, 16'h2222, 6'h0C, 1'b0, 1'b0, acc, drn);
      check("full_in_ready", 64'(b32.in_ready), 64'd0);
      cycle(1'b1, 16'hDEAD, 6'h0E, 1'b0, 1'b1, acc, drn);
      check("flush_out_valid", 64'(b32.out_valid), 64'd0);
      check("flush_in_ready", 64'(b32.in_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
         cycle(1'b0, 16'h0000, 6'h00, 1'b1, 1'b0, acc, drn);
         check("flush_no_ghost", 64'(b32.out_valid), 64'd0);
      end

      // Randomized handshake against the queue model.
      for (int c = 0; c < 10000; c++) begin
         imm = 16'($urandom);
         opc = ($urandom_range(0, 2) == 0) ? 6'(6'h0C + $urandom_range(0, 3)) : 6'($urandom);
         cycle($urandom_range(0, 1) == 1, imm, opc, $urandom_range(0, 2) != 0,
               $urandom_range(0, 63) == 0, acc, drn);
      end

      // 64-bit instance at the extremes of sign-extension and upper-load.
      b64.in_valid  = 1'b1;
      b64.in_imm    = 16'hFFFF;
      b64.in_opcode = 6'h08;
      step();
      check("w64_sext", b64.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      check("w64_sext_ref", b64.out_data, ref_ext(64, 16'hFFFF, 6'h08).data);
      b64.in_opcode = 6'h0F;
      step();
      check("w64_lui", b64.out_data, 64'hFFFF_0000_0000_0000);
      check("w64_lui_mode", 64'(b64.out_mode), 64'd2);
      b64.in_valid = 1'b0;
      step();
      check("w64_idle", 64'(b64.out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
